data_sram_responder: RTL and testbench

- SRAM-like slave model for the data-side request interface driven by the execute stage: accepts `req/wr/size/wstrb/addr/wdata` on `addr_ok`, returns `data_ok/rdata` a fixed number of cycles later.
- Backed by an internal word array. Supports multiple outstanding requests, strictly in order.
- Used as the data memory in core-level simulation and as the target for pipeline handshake verification. A configurable address-phase stall exercises requester wait states.

---
 rtl/data_sram_responder_pkg.sv | 35 +++
 rtl/data_sram_responder_if.sv | 24 ++
 rtl/data_sram_responder_sram_req_queue.sv | 80 ++++++++
 rtl/data_sram_responder.sv | 86 ++++++++
 tb/tb_data_sram_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data-side SRAM responder.
// Size encodings, queue entry width and the lane/alignment rules used by the protocol checker.
package data_sram_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // {wr, word index, wstrb, wdata}
  function automatic int unsigned sram_req_entry_width(int unsigned addr_bits);
    return 1 + addr_bits + 4 + 32;
  endfunction

  function automatic logic [3:0] size_lane_mask(logic [1:0] size, logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << addr_lo;
      SIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic size_misaligned(logic [1:0] size, logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-side SRAM request/response bundle between the execute stage (master) and memory (slave).
interface data_sram_responder_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/data_sram_responder_sram_req_queue.sv
// In-order outstanding-request FIFO; each entry counts down from Latency-1 and the head
// is ready once its countdown reaches zero.
module data_sram_responder_sram_req_queue #(
  parameter int unsigned Depth   = 2,
  parameter int unsigned Latency = 2,
  parameter int unsigned Width   = 47
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_data_o,
  output logic             head_ready_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CdW  = (Latency > 1) ? $clog2(Latency) : 1;

  logic [Width-1:0] data_q [Depth];
  logic [CdW-1:0]   cd_q   [Depth];
  logic [CdW-1:0]   cd_d   [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    valid_d  = valid_q;
    cd_d     = cd_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_q[i] && (cd_q[i] != '0)) begin
        cd_d[i] = cd_q[i] - 1'b1;
      end
    end
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end
    // Push only happens when not full, so it never lands on the slot being popped.
    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      cd_d[wr_ptr_q]    = CdW'(Latency - 1);
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        cd_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cd_q     <= cd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_data_o  = data_q[rd_ptr_q];
  assign head_ready_o = valid_q[rd_ptr_q] && (cd_q[rd_ptr_q] == '0);
  assign full_o       = &valid_q;

endmodule

// File: rtl/data_sram_responder.sv
// SRAM-like data memory slave: accepts requests on addr_ok, completes them in order with
// data_ok a fixed LATENCY later, and flags malformed requests on a sticky proto_err.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS       = 10,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned LATENCY         = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  data_sram_responder_if.slave        data_sram,
  input  logic                        addr_stall,
  output logic                        proto_err
);

  localparam int unsigned EntryW = sram_req_entry_width(ADDR_BITS);
  localparam int unsigned Words  = 1 << ADDR_BITS;

  logic [31:0]          mem_q [Words];
  logic                 full;
  logic                 head_ready;
  logic                 accept;
  logic [EntryW-1:0]    push_entry;
  logic [EntryW-1:0]    head_entry;
  logic                 head_wr;
  logic [ADDR_BITS-1:0] head_idx;
  logic [3:0]           head_strb;
  logic [31:0]          head_wdata;
  logic                 req_bad;
  logic                 proto_err_q, proto_err_d;
  logic                 unused_addr_hi;

  data_sram_responder_sram_req_queue #(
    .Depth   (MAX_OUTSTANDING),
    .Latency (LATENCY),
    .Width   (EntryW)
  ) u_queue (
    .clk_i        (clk),
    .rst_i        (reset),
    .push_i       (accept),
    .push_data_i  (push_entry),
    .pop_i        (head_ready),
    .head_data_o  (head_entry),
    .head_ready_o (head_ready),
    .full_o       (full)
  );

  always_comb begin
    // Occupancy is the registered value, so a same-cycle pop cannot admit a new request.
    data_sram.addr_ok = ~reset & data_sram.req & ~addr_stall & ~full;
    accept            = data_sram.req & data_sram.addr_ok;
    push_entry        = {data_sram.wr, data_sram.addr[ADDR_BITS+1:2], data_sram.wstrb,
                         data_sram.wdata};
    {head_wr, head_idx, head_strb, head_wdata} = head_entry;
    data_sram.data_ok = head_ready;
    data_sram.rdata   = (head_ready & ~head_wr) ? mem_q[head_idx] : 32'h0;
    req_bad = size_misaligned(data_sram.size, data_sram.addr[1:0]) |
              (data_sram.wr &
               (|(data_sram.wstrb & ~size_lane_mask(data_sram.size, data_sram.addr[1:0]))));
    proto_err_d = proto_err_q | (accept & req_bad);
  end

  // Writes commit in order at completion, so later reads always see them.
  always_ff @(posedge clk) begin
    if (head_ready & head_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (head_strb[b]) begin
          mem_q[head_idx][8*b +: 8] <= head_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err      = proto_err_q;
  assign unused_addr_hi = ^data_sram.addr[31:ADDR_BITS+2];

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: vector table, handshake corner sequences and randomized
// traffic, all checked against a due-time queue / byte-array reference model.
module tb_data_sram_responder;

  localparam int unsigned AB   = 10;
  localparam int unsigned MAXO = 2;
  localparam int unsigned LAT  = 2;
  localparam int unsigned NW   = 1 << AB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic addr_stall = 1'b0;
  logic proto_err;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  data_sram_responder_if bus ();

  data_sram_responder #(
    .ADDR_BITS       (AB),
    .MAX_OUTSTANDING (MAXO),
    .LATENCY         (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_sram  (bus),
    .addr_stall (addr_stall),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          wr;
    int          idx;
    logic [3:0]  strb;
    logic [31:0] wd;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] ref_mem   [NW];
  logic [3:0]  ref_known [NW];
  bit          ref_proto;

  function automatic bit viol(bit wr, logic [1:0] sz, logic [31:0] a, logic [3:0] st);
    int off, n;
    if (sz == 2'b11) return 1'b1;
    n   = 1 << sz;
    off = int'(a[1:0]);
    if (off % n != 0) return 1'b1;
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (st[i] && (i < off || i >= off + n)) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    bit          e_dok, e_aok, rd_known;
    logic [31:0] e_rd;
    pend_t       p;
    if (reset) begin
      pq.delete();
      ref_proto = 1'b0;
      check("rst_addr_ok", 32'(bus.addr_ok), 32'h0);
      check("rst_data_ok", 32'(bus.data_ok), 32'h0);
      check("rst_rdata", bus.rdata, 32'h0);
      check("rst_proto", 32'(proto_err), 32'h0);
    end else begin
      e_dok    = (pq.size() > 0) && (pq[0].due == cyc);
      e_rd     = 32'h0;
      rd_known = 1'b1;
      if (e_dok && !pq[0].wr) begin
        e_rd     = ref_mem[pq[0].idx];
        rd_known = (ref_known[pq[0].idx] == 4'hF);
      end
      e_aok = bus.req && !addr_stall && (pq.size() < MAXO);
      check("mon_addr_ok", 32'(bus.addr_ok), 32'(e_aok));
      check("mon_data_ok", 32'(bus.data_ok), 32'(e_dok));
      check("mon_proto", 32'(proto_err), 32'(ref_proto));
      if (rd_known) check("mon_rdata", bus.rdata, e_rd);
      if (e_dok) begin
        p = pq.pop_front();
        if (p.wr) begin
          for (int b = 0; b < 4; b++) begin
            if (p.strb[b]) begin
              ref_mem[p.idx][8*b +: 8] = p.wd[8*b +: 8];
              ref_known[p.idx][b]      = 1'b1;
            end
          end
        end
      end
      if (e_aok) begin
        p.due  = cyc + LAT;
        p.wr   = bus.wr;
        p.idx  = int'((bus.addr >> 2) % NW);
        p.strb = bus.wstrb;
        p.wd   = bus.wdata;
        pq.push_back(p);
        if (viol(bus.wr, bus.size, bus.addr, bus.wstrb)) ref_proto = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rq, input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] st, input logic [31:0] d);
    bus.req   = rq;
    bus.wr    = w;
    bus.size  = sz;
    bus.addr  = a;
    bus.wstrb = st;
    bus.wdata = d;
  endtask

  task automatic do_txn(input bit w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    bit ok, got;
    int acc;
    ok  = 1'b0;
    got = 1'b0;
    acc = 0;
    rd  = 32'hX;
    lat = -1;
    drive(1'b1, w, sz, a, st, d);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.addr_ok) begin
        ok  = 1'b1;
        acc = cyc;
      end
      tick();
      if (ok) break;
    end
    bus.req = 1'b0;
    check("txn_accept", 32'(ok), 32'h1);
    for (int i = 0; i < 20 && ok; i++) begin
      @(negedge clk);
      if (bus.data_ok) begin
        got = 1'b1;
        lat = cyc - acc;
        rd  = bus.rdata;
      end
      tick();
      if (got) break;
    end
    check("txn_done", 32'(got), 32'h1);
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [31:0] rd;
    int          lat, base, n_acc, n_dok, acc_rel, dok_rel;
    bit          aok[4];
    int          dok_cyc[$];

    for (int i = 0; i < int'(NW); i++) begin
      ref_mem[i]   = 32'h0;
      ref_known[i] = 4'h0;
    end
    drive(1'b0, 1'b0, 2'b10, 32'h0, 4'h0, 32'h0);

    vt[0] = '{1'b1, 2'b10, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 2'b10, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b1, 2'b00, 32'h11,   4'h2, 32'h55555555, 32'h0};
    vt[3] = '{1'b0, 2'b10, 32'h10,   4'h0, 32'h0,        32'hDEAD55EF};
    vt[4] = '{1'b1, 2'b01, 32'h12,   4'hC, 32'h12341234, 32'h0};
    vt[5] = '{1'b0, 2'b10, 32'h10,   4'h0, 32'h0,        32'h123455EF};
    vt[6] = '{1'b1, 2'b10, 32'h1000, 4'hF, 32'hCAFEF00D, 32'h0};
    vt[7] = '{1'b0, 2'b10, 32'h0,    4'h0, 32'h0,        32'hCAFEF00D};
    vt[8] = '{1'b1, 2'b10, 32'h20,   4'hF, 32'hA5A5A5A5, 32'h0};
    vt[9] = '{1'b0, 2'b10, 32'h20,   4'h0, 32'h0,        32'hA5A5A5A5};

    @(negedge clk);
    check("reset_data_ok", 32'(bus.data_ok), 32'h0);
    check("reset_proto", 32'(proto_err), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    foreach (vt[i]) begin
      do_txn(vt[i].wr, vt[i].sz, vt[i].addr, vt[i].strb, vt[i].wd, rd, lat);
      check("vec_rdata", rd, vt[i].exp_rd);
      check("vec_latency", 32'(lat), 32'(LAT));
    end

    // Three reads held back-to-back against a two-deep queue.
    drive(1'b1, 1'b0, 2'b10, 32'h10, 4'h0, 32'h0);
    base  = cyc;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 4) aok[i] = bus.addr_ok;
      if (bus.addr_ok) n_acc++;
      if (bus.data_ok) dok_cyc.push_back(cyc - base);
      tick();
      if (n_acc == 3) bus.req = 1'b0;
    end
    check("b2b_aok0", 32'(aok[0]), 32'h1);
    check("b2b_aok1", 32'(aok[1]), 32'h1);
    check("b2b_aok2", 32'(aok[2]), 32'h0);
    check("b2b_aok3", 32'(aok[3]), 32'h1);
    check("b2b_ndok", 32'(dok_cyc.size()), 32'd3);
    if (dok_cyc.size() == 3) begin
      check("b2b_dok0", 32'(dok_cyc[0]), 32'd2);
      check("b2b_dok1", 32'(dok_cyc[1]), 32'd3);
      check("b2b_dok2", 32'(dok_cyc[2]), 32'd5);
    end

    // Write then read of the same word in consecutive cycles.
    drive(1'b1, 1'b1, 2'b10, 32'h30, 4'hF, 32'h0BADF00D);
    @(negedge clk);
    check("raw_acc_wr", 32'(bus.addr_ok), 32'h1);
    tick();
    drive(1'b1, 1'b0, 2'b10, 32'h30, 4'h0, 32'h0);
    @(negedge clk);
    check("raw_acc_rd", 32'(bus.addr_ok), 32'h1);
    tick();
    bus.req = 1'b0;
    n_dok   = 0;
    rd      = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.data_ok) begin
        n_dok++;
        if (n_dok == 2) rd = bus.rdata;
      end
      tick();
    end
    check("raw_ndok", 32'(n_dok), 32'd2);
    check("raw_rdata", rd, 32'h0BADF00D);

    // Address-phase stall for three cycles.
    drive(1'b1, 1'b0, 2'b10, 32'h10, 4'h0, 32'h0);
    base    = cyc;
    acc_rel = -1;
    dok_rel = -1;
    for (int i = 0; i < 8; i++) begin
      addr_stall = (i < 3);
      @(negedge clk);
      if (i < 4) aok[i] = bus.addr_ok;
      if (bus.addr_ok && acc_rel < 0) acc_rel = cyc - base;
      if (bus.data_ok && dok_rel < 0) dok_rel = cyc - base;
      tick();
      if (acc_rel >= 0) bus.req = 1'b0;
    end
    addr_stall = 1'b0;
    check("stall_aok0", 32'(aok[0]), 32'h0);
    check("stall_aok2", 32'(aok[2]), 32'h0);
    check("stall_acc", 32'(acc_rel), 32'd3);
    check("stall_dok", 32'(dok_rel), 32'd5);

    // Reset while a write is pending: write is lost, old contents survive.
    drive(1'b1, 1'b1, 2'b10, 32'h20, 4'hF, 32'h11111111);
    @(negedge clk);
    check("rstmid_acc", 32'(bus.addr_ok), 32'h1);
    tick();
    bus.req = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    n_dok = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.data_ok) n_dok++;
      tick();
    end
    check("rstmid_ndok", 32'(n_dok), 32'h0);
    do_txn(1'b0, 2'b10, 32'h20, 4'h0, 32'h0, rd, lat);
    check("rstmid_rdata", rd, 32'hA5A5A5A5);

    // Misaligned word read sets the sticky flag.
    drive(1'b1, 1'b0, 2'b10, 32'h22, 4'h0, 32'h0);
    @(negedge clk);
    check("perr_acc", 32'(bus.addr_ok), 32'h1);
    check("perr_before", 32'(proto_err), 32'h0);
    tick();
    bus.req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("perr_sticky", 32'(proto_err), 32'h1);
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    check("perr_cleared", 32'(proto_err), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Randomized traffic; the monitor model checks every cycle.
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  sz;
      logic [1:0]  off;
      logic [3:0]  st;
      logic [31:0] a;
      if (i == 200) reset = 1'b1;
      if (i == 201) reset = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        sz  = 2'($urandom_range(0, 3));
        off = 2'($urandom_range(0, 3));
        st  = 4'($urandom_range(0, 15));
      end else begin
        sz  = 2'($urandom_range(0, 2));
        off = (sz == 2'b00) ? 2'($urandom_range(0, 3)) :
              (sz == 2'b01) ? 2'($urandom_range(0, 1) * 2) : 2'b00;
        st  = (sz == 2'b10) ? 4'hF : (sz == 2'b01) ? (4'b0011 << off) : (4'b0001 << off);
        if ($urandom_range(0, 7) == 0) st = 4'h0;
      end
      a = (32'($urandom_range(0, 1)) << (AB + 2)) | (32'($urandom_range(0, 7)) << 2) |
          32'(off);
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), sz, a, st, $urandom);
      addr_stall = ($urandom_range(0, 4) == 0);
      tick();
    end
    bus.req    = 1'b0;
    addr_stall = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
